// File: rtl/fpu_norm_round.sv
// Iterative normalize-and-round stage: shifts the raw mantissa one bit per clock, applies
// round-to-nearest-even and packs an IEEE-754 single with overflow/underflow/inexact flags.
module fpu_norm_round #(
    parameter int unsigned MANT_W = 48
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [9:0]        in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_ovf,
    output logic              out_unf,
    output logic              out_inexact,
    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic signed [10:0] exp_q, exp_d;
    logic [MANT_W-1:0]  mant_q, mant_d;
    logic               sticky_q, sticky_d;
    logic [31:0]        result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic               inexact_q, inexact_d;

    logic [22:0]        frac;
    logic               guard;
    logic               sticky_all;
    logic               round_up;
    logic [23:0]        frac_inc;
    logic signed [10:0] exp_rnd;
    logic signed [10:0] biased;

    // Rounding datapath, only meaningful once the mantissa is normalized.
    assign frac       = mant_q[MANT_W-3 -: 23];
    assign guard      = mant_q[MANT_W-26];
    assign sticky_all = sticky_q | (|mant_q[MANT_W-27:0]);
    assign round_up   = guard & (sticky_all | frac[0]);
    assign frac_inc   = {1'b0, frac} + {23'd0, round_up};
    assign exp_rnd    = exp_q + $signed({10'd0, frac_inc[23]});
    assign biased     = exp_rnd + 11'sd127;

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        mant_d    = mant_q;
        sticky_d  = sticky_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        inexact_d = inexact_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    exp_d    = {in_exp[9], in_exp};
                    mant_d   = in_mant;
                    sticky_d = 1'b0;
                    state_d  = StNorm;
                end
            end
            StNorm: begin
                // A zero mantissa still spends one cycle in ROUND so its latency is two edges.
                if (mant_q == '0) begin
                    state_d = StRound;
                end else if (mant_q[MANT_W-1]) begin
                    mant_d   = mant_q >> 1;
                    sticky_d = sticky_q | mant_q[0];
                    exp_d    = exp_q + 11'sd1;
                end else if (!mant_q[MANT_W-2]) begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - 11'sd1;
                end else begin
                    state_d = StRound;
                end
            end
            StRound: begin
                state_d = StDone;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                if (mant_q == '0) begin
                    result_d  = {sign_q, 31'b0};
                    inexact_d = 1'b0;
                end else if (biased >= 11'sd255) begin
                    result_d  = {sign_q, 8'hFF, 23'b0};
                    ovf_d     = 1'b1;
                    inexact_d = 1'b1;
                end else if (biased <= 11'sd0) begin
                    result_d  = {sign_q, 31'b0};
                    unf_d     = 1'b1;
                    inexact_d = 1'b1;
                end else begin
                    result_d  = {sign_q, biased[7:0], frac_inc[22:0]};
                    inexact_d = guard | sticky_all;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q   <= StIdle;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            sticky_q  <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            mant_q    <= mant_d;
            sticky_q  <= sticky_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            inexact_q <= inexact_d;
        end
    end

    assign in_ready    = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign out_valid   = (state_q == StDone);
    assign out_result  = result_q;
    assign out_ovf     = ovf_q;
    assign out_unf     = unf_q;
    assign out_inexact = inexact_q;

endmodule

// File: tb/tb_fpu_norm_round.sv
// Directed bench for fpu_norm_round: hand-computed results, flags, latency, stall and reset.
module tb_fpu_norm_round;

    logic        clk = 1'b0;
    logic        arst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_ovf;
    logic        out_unf;
    logic        out_inexact;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    fpu_norm_round #(.MANT_W(48)) dut (
        .clk        (clk),
        .arst       (arst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ovf    (out_ovf),
        .out_unf    (out_unf),
        .out_inexact(out_inexact),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Launch one operation, measure latency, optionally stall in DONE, then hand it off.
    task automatic run_op(input string tag, input logic sgn, input logic [9:0] ex,
                          input logic [47:0] mt, input logic [31:0] e_res,
                          input logic [2:0] e_flags, input int e_lat, input int stall);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_sign  = sgn;
        in_exp   = ex;
        in_mant  = mt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " busy"}, {31'd0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, e_lat);
        check({tag, " result"}, out_result, e_res);
        check({tag, " flags"}, {29'd0, out_ovf, out_unf, out_inexact}, {29'd0, e_flags});
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_sign  = 1'b0;
            in_exp   = 10'($urandom);
            in_mant  = {16'($urandom), 32'($urandom)};
            @(posedge clk); #1;
            check({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, " hold result"}, out_result, e_res);
            check({tag, " hold flags"}, {29'd0, out_ovf, out_unf, out_inexact},
                  {29'd0, e_flags});
            check({tag, " hold in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " idle after"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        arst      = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        out_ready = 1'b0;
        #12;
        check("reset outs", {27'd0, out_valid, out_ovf, out_unf, out_inexact, busy}, 32'd0);
        check("reset result", out_result, 32'd0);
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        arst = 1'b0;
        @(posedge clk); #1;

        run_op("norm1",    1'b0, 10'd0,        48'h1 << 46,      32'h3F800000, 3'b000, 2,  0);
        run_op("rshift",   1'b0, 10'd0,        48'h3 << 46,      32'h40400000, 3'b000, 3,  0);
        run_op("negzero",  1'b1, 10'd0,        48'h0,            32'h80000000, 3'b000, 2,  0);
        run_op("lshift6",  1'b0, 10'd0,        48'h1 << 40,      32'h3C800000, 3'b000, 8,  0);
        run_op("lsh_unf",  1'b0, -10'sd506,    48'h1 << 40,      32'h00000000, 3'b011, 8,  0);
        run_op("tie_odd",  1'b0, 10'd0,        48'h7FFFFFC00000, 32'h40000000, 3'b001, 2,  0);
        run_op("tie_even", 1'b0, 10'd0,        48'h7FFFFF400000, 32'h3FFFFFFE, 3'b001, 2,  0);
        run_op("sticky",   1'b0, 10'd0,        48'h400000000001, 32'h3F800000, 3'b001, 2,  0);
        run_op("ovf",      1'b0, 10'd128,      48'h1 << 46,      32'h7F800000, 3'b101, 2,  0);
        run_op("unf",      1'b1, -10'sd127,    48'h1 << 46,      32'h80000000, 3'b011, 2,  0);
        run_op("maxnorm",  1'b0, 10'd127,      48'h1 << 46,      32'h7F000000, 3'b000, 2,  0);
        run_op("minnorm",  1'b0, -10'sd126,    48'h1 << 46,      32'h00800000, 3'b000, 2,  0);
        run_op("rnd_ovf",  1'b0, 10'd127,      48'h7FFFFFC00000, 32'h7F800000, 3'b101, 2,  0);
        run_op("rs_stky",  1'b0, 10'd0,        (48'h1 << 47) | 48'h1,
               32'h40000000, 3'b001, 3, 0);
        run_op("lsh_max",  1'b0, 10'd0,        48'h1,            32'h28800000, 3'b000, 48, 0);
        run_op("stall",    1'b1, 10'd3,        48'h3 << 46,      32'hC1C00000, 3'b000, 3,  10);

        // Abort an operation mid-NORM with an asynchronous reset.
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 10'd0;
        in_mant  = 48'h1 << 40;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-abort busy", {31'd0, busy}, 32'd1);
        arst = 1'b1;
        #1;
        check("abort outs", {30'd0, out_valid, busy}, 32'd0);
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort result", out_result, 32'd0);
        #2;
        arst = 1'b0;
        @(posedge clk); #1;
        check("post-abort no valid", {31'd0, out_valid}, 32'd0);
        run_op("after_rst", 1'b0, 10'd0, 48'h1 << 46, 32'h3F800000, 3'b000, 2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
